xoodoo_perm_arbiter: RTL

XOODOO_PERM_ARBITER -- requirements
Module: xoodoo_perm_arbiter

---
 rtl/xoodoo_pkg.sv | 19 +
 rtl/xoodoo_rr_pick.sv | 15 +
 rtl/xoodoo_perm_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/xoodoo_pkg.sv
// Shared definitions for the Xoodoo permutation arbiter.
package xoodoo_pkg;

  localparam int unsigned STATE_W         = 384;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } fsm_state_e;

  // Expand a requester index into its two-bit one-hot strobe.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/xoodoo_rr_pick.sv
// Two-way round-robin pick: on a tie the requester other than last_grant wins.
module xoodoo_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  // Lone requester always wins; a tie goes to the one not served last.
  always_comb begin
    any   = |valid;
    grant = (valid == 2'b11) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/xoodoo_perm_arbiter.sv
// Arbitrates two requesters onto one Xoodoo permutation core, with a timeout.
module xoodoo_perm_arbiter
  import xoodoo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [STATE_W-1:0] req_state0,
  input  logic [STATE_W-1:0] req_state1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [STATE_W-1:0] rsp_state,
  output logic               rsp_err,
  output logic               core_start,
  output logic [STATE_W-1:0] core_state_in,
  input  logic               core_done,
  input  logic [STATE_W-1:0] core_state_out,
  output logic               busy,
  output logic               grant_id
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fsm_state_e         state;
  fsm_state_e         state_n;
  logic [STATE_W-1:0] buffer;
  logic [STATE_W-1:0] buffer_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               last_grant;
  logic               last_grant_n;
  logic               grant_n;
  logic               err_n;
  logic               pick_grant;
  logic               pick_any;

  xoodoo_rr_pick u_rr_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // The buffer carries the input state to the core and the result back out.
  assign core_state_in = buffer;
  assign rsp_state     = buffer;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, handshake and datapath-update decode.
  always_comb begin
    state_n      = state;
    req_ready    = 2'b00;
    buffer_n     = buffer;
    cnt_n        = cnt;
    grant_n      = grant_id;
    err_n        = rsp_err;
    last_grant_n = last_grant;
    unique case (state)
      IDLE: begin
        // The picked requester is valid by construction, so ready implies accept.
        if (pick_any && resetn) begin
          req_ready = onehot2(pick_grant);
          buffer_n  = pick_grant ? req_state1 : req_state0;
          grant_n   = pick_grant;
          err_n     = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        if (core_done) begin
          buffer_n = core_state_out;
          err_n    = 1'b0;
          state_n  = RESP;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_id]) begin
          last_grant_n = grant_id;
          state_n      = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buffer     <= '0;
      cnt        <= '0;
      grant_id   <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      buffer     <= buffer_n;
      cnt        <= cnt_n;
      grant_id   <= grant_n;
      rsp_err    <= err_n;
      last_grant <= last_grant_n;
    end
  end

  // Status outputs registered from the next-state decode so they track the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid  <= 2'b00;
      core_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rsp_valid  <= (state_n == RESP) ? onehot2(grant_n) : 2'b00;
      core_start <= (state_n == START);
      busy       <= (state_n != IDLE);
    end
  end

endmodule
